// File: rtl/biu_pkg.sv
// Shared definitions for the BIU configuration-programming path: state encoding,
// SDRAM timing field layout, default programming address and the word pack helper.
package biu_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned RETRY_W     = 3;

  localparam int unsigned TBURST_W    = 3;
  localparam int unsigned ADDR_MODE_W = 1;
  localparam int unsigned TLAT_W      = 4;
  localparam int unsigned TPRE_W      = 8;
  localparam int unsigned TWAIT_W     = 8;
  localparam int unsigned TCAS_W      = 8;

  localparam int unsigned TBURST_LSB    = 0;
  localparam int unsigned ADDR_MODE_LSB = 3;
  localparam int unsigned TLAT_LSB      = 4;
  localparam int unsigned TPRE_LSB      = 8;
  localparam int unsigned TWAIT_LSB     = 16;
  localparam int unsigned TCAS_LSB      = 24;

  localparam logic [ADDR_W-1:0] CFG_ADDR_DEF = 32'h3FFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WAIT,
    CHECK,
    DONE,
    ERR
  } cfg_state_e;

  typedef struct packed {
    logic [TCAS_W-1:0]      tcas;
    logic [TWAIT_W-1:0]     twait;
    logic [TPRE_W-1:0]      tpre;
    logic [TLAT_W-1:0]      tlat;
    logic [ADDR_MODE_W-1:0] addr_mode;
    logic [TBURST_W-1:0]    tburst;
  } sdram_cfg_t;

  // Place each timing field at its register-file bit position.
  function automatic logic [WORD_W-1:0] pack_cfg(input sdram_cfg_t c);
    logic [WORD_W-1:0] w;
    w = '0;
    w[TCAS_LSB      +: TCAS_W]      = c.tcas;
    w[TWAIT_LSB     +: TWAIT_W]     = c.twait;
    w[TPRE_LSB      +: TPRE_W]      = c.tpre;
    w[TLAT_LSB      +: TLAT_W]      = c.tlat;
    w[ADDR_MODE_LSB +: ADDR_MODE_W] = c.addr_mode;
    w[TBURST_LSB    +: TBURST_W]    = c.tburst;
    return w;
  endfunction

endpackage

// File: rtl/biu_cfg_master_if.sv
// Programming bus between the configuration initiator and the BIU register file.
interface biu_cfg_master_if;
  import biu_pkg::*;

  logic [ADDR_W-1:0] AddrOut;
  logic [WORD_W-1:0] DataOut;
  logic              EnOut;
  logic              MasterBusy;

  modport master (output AddrOut, DataOut, EnOut, input MasterBusy);
  modport slave  (input AddrOut, DataOut, EnOut, output MasterBusy);

endinterface

// File: rtl/biu_cfg_pack.sv
// Combinational packing of the latched timing set and comparison against readback.
module biu_cfg_pack
  import biu_pkg::*;
(
  input  sdram_cfg_t        cfg_i,
  input  sdram_cfg_t        rb_i,
  input  logic              rb_prog_mode_i,
  output logic [WORD_W-1:0] word_c_o,
  output logic              match_c_o
);

  assign word_c_o  = pack_cfg(cfg_i);
  assign match_c_o = (rb_i == cfg_i) && rb_prog_mode_i;

endmodule

// File: rtl/biu_cfg_master.sv
// BIU configuration initiator: latches a timing set, writes address then data phase.
// Readback verify with retry is built only when BIU_CFG_VERIFY_EN is defined.
module biu_cfg_master
  import biu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CFG_ADDR   = CFG_ADDR_DEF,
  parameter int unsigned       VERIFY_LAT = 2,
  parameter int unsigned       MAX_RETRY  = 3
) (
  input  logic                    Clk,
  input  logic                    Rst,
  biu_cfg_master_if.master        bus,
  input  logic                    Start,
  input  logic [TBURST_W-1:0]     cfg_tburst,
  input  logic [ADDR_MODE_W-1:0]  cfg_addr_mode,
  input  logic [TLAT_W-1:0]       cfg_tlat,
  input  logic [TPRE_W-1:0]       cfg_tpre,
  input  logic [TWAIT_W-1:0]      cfg_twait,
  input  logic [TCAS_W-1:0]       cfg_tcas,
  input  logic [TBURST_W-1:0]     rb_tburst,
  input  logic [ADDR_MODE_W-1:0]  rb_addr_mode,
  input  logic [TLAT_W-1:0]       rb_tlat,
  input  logic [TPRE_W-1:0]       rb_tpre,
  input  logic [TWAIT_W-1:0]      rb_twait,
  input  logic [TCAS_W-1:0]       rb_tcas,
  input  logic                    rb_prog_mode,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Error
);

  cfg_state_e         state_q, state_d;
  logic               start_q, start_d;
  sdram_cfg_t         cfg_q, cfg_d, cfg_in_c, rb_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  data_q, data_d, word_c;
  logic               en_q, en_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic               match_c;

  assign cfg_in_c = '{tcas: cfg_tcas, twait: cfg_twait, tpre: cfg_tpre, tlat: cfg_tlat,
                      addr_mode: cfg_addr_mode, tburst: cfg_tburst};
  assign rb_c     = '{tcas: rb_tcas, twait: rb_twait, tpre: rb_tpre, tlat: rb_tlat,
                      addr_mode: rb_addr_mode, tburst: rb_tburst};

  biu_cfg_pack u_pack (
    .cfg_i          (cfg_q),
    .rb_i           (rb_c),
    .rb_prog_mode_i (rb_prog_mode),
    .word_c_o       (word_c),
    .match_c_o      (match_c)
  );

`ifndef BIU_CFG_VERIFY_EN
  logic unused_verify;
  assign unused_verify = ^{match_c, 32'(VERIFY_LAT), 32'(MAX_RETRY)};
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      cfg_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // start_q spends one cycle latching the request so the ADDR phase shows one edge after Start.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    error_d = error_q;

    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = ADDR;
        end else if (Start) begin
          start_d = 1'b1;
          cfg_d   = cfg_in_c;
          retry_d = '0;
          error_d = 1'b0;
        end
      end
      ADDR: if (!bus.MasterBusy) state_d = DATA;
      DATA: begin
        if (!bus.MasterBusy) begin
`ifdef BIU_CFG_VERIFY_EN
          state_d = WAIT;
          cnt_d   = CNT_W'(VERIFY_LAT);
`else
          state_d = DONE;
`endif
        end
      end
`ifdef BIU_CFG_VERIFY_EN
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = CHECK;
      end
      CHECK: begin
        if (match_c) begin
          state_d = DONE;
        end else if (32'(retry_q) < MAX_RETRY) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = ADDR;
        end else begin
          state_d = ERR;
        end
      end
      ERR:  state_d = IDLE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    addr_d = (state_d == ADDR) ? CFG_ADDR : '0;
    data_d = (state_d == DATA) ? word_c : '0;
    en_d   = (state_d == ADDR) || (state_d == DATA) || (state_d == WAIT);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    if (state_d == ERR) error_d = 1'b1;
  end

  assign bus.AddrOut = addr_q;
  assign bus.DataOut = data_q;
  assign bus.EnOut   = en_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_biu_cfg_master.sv
// Directed bench for biu_cfg_master; expectations follow the verify build when
// BIU_CFG_VERIFY_EN is defined, otherwise the plain write-only build.
module tb_biu_cfg_master;

  localparam logic [31:0] CFG_A = 32'h3FFF_FFFF;
`ifdef BIU_CFG_VERIFY_EN
  localparam int DONE_LAT = 6;
`else
  localparam int DONE_LAT = 3;
`endif

  logic       Clk;
  logic       Rst, Start;
  logic [2:0] cfg_tburst, rb_tburst;
  logic       cfg_addr_mode, rb_addr_mode;
  logic [3:0] cfg_tlat, rb_tlat;
  logic [7:0] cfg_tpre, cfg_twait, cfg_tcas, rb_tpre, rb_twait, rb_tcas;
  logic       rb_prog_mode;
  logic       Busy, Done, Error;

  int n_checks;
  int n_fail;

  biu_cfg_master_if bus_if ();

  biu_cfg_master dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .bus           (bus_if),
    .Start         (Start),
    .cfg_tburst    (cfg_tburst),
    .cfg_addr_mode (cfg_addr_mode),
    .cfg_tlat      (cfg_tlat),
    .cfg_tpre      (cfg_tpre),
    .cfg_twait     (cfg_twait),
    .cfg_tcas      (cfg_tcas),
    .rb_tburst     (rb_tburst),
    .rb_addr_mode  (rb_addr_mode),
    .rb_tlat       (rb_tlat),
    .rb_tpre       (rb_tpre),
    .rb_twait      (rb_twait),
    .rb_tcas       (rb_tcas),
    .rb_prog_mode  (rb_prog_mode),
    .Busy          (Busy),
    .Done          (Done),
    .Error         (Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] tcas, input logic [7:0] twait, input logic [7:0] tpre,
                         input logic [3:0] tlat, input logic mode, input logic [2:0] burst);
    cfg_tcas = tcas; cfg_twait = twait; cfg_tpre = tpre;
    cfg_tlat = tlat; cfg_addr_mode = mode; cfg_tburst = burst;
  endtask

  task automatic rb_from_cfg();
    rb_tcas = cfg_tcas; rb_twait = cfg_twait; rb_tpre = cfg_tpre;
    rb_tlat = cfg_tlat; rb_addr_mode = cfg_addr_mode; rb_tburst = cfg_tburst;
    rb_prog_mode = 1'b1;
  endtask

  // Steps until Done is seen; cycle numbers count edges after the Start edge.
  task automatic run_to_done(input int cyc0, output int done_at);
    int cyc;
    cyc = cyc0;
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (Done === 1'b1) begin
        done_at = cyc;
        break;
      end
      step();
      cyc++;
    end
  endtask

  task automatic run_txn(input bit fix_prog, output int n_addr, output int done_at,
                         output int err_at, output logic err0);
    logic prev_addr;
    n_addr = 0; done_at = -1; err_at = -1; prev_addr = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    err0 = Error;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (bus_if.AddrOut == CFG_A && !prev_addr) begin
        n_addr++;
        if (fix_prog && n_addr == 2) rb_prog_mode = 1'b1;
      end
      prev_addr = (bus_if.AddrOut == CFG_A);
      if (Done === 1'b1 && done_at < 0) done_at = cyc;
      if (Error === 1'b1 && err_at < 0) err_at = cyc;
      if (done_at >= 0 || err_at >= 0) break;
    end
  endtask

  initial begin
    int   done_at, err_at, n_addr, cnt_en, cnt_done, cnt_err;
    logic err0;
    n_checks = 0; n_fail = 0;
    Rst = 1'b1; Start = 1'b0; bus_if.MasterBusy = 1'b0;
    set_cfg(8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 3'h0);
    rb_from_cfg();
    rb_prog_mode = 1'b0;
    step(); step();
    Rst = 1'b0;
    check_eq("rst_addr", bus_if.AddrOut, 32'h0);
    check_eq("rst_data", bus_if.DataOut, 32'h0);
    check_eq("rst_en", 32'(bus_if.EnOut), 32'h0);
    check_eq("rst_busy", 32'(Busy), 32'h0);
    check_eq("rst_done", 32'(Done), 32'h0);
    check_eq("rst_error", 32'(Error), 32'h0);

    // Unstalled program of 060708AF
    set_cfg(8'h06, 8'h07, 8'h08, 4'hA, 1'b1, 3'h7);
    rb_from_cfg();
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("t1_n0_en", 32'(bus_if.EnOut), 32'h0);
    step();
    check_eq("t1_addr", bus_if.AddrOut, CFG_A);
    check_eq("t1_addr_data", bus_if.DataOut, 32'h0);
    check_eq("t1_addr_en", 32'(bus_if.EnOut), 32'h1);
    check_eq("t1_busy", 32'(Busy), 32'h1);
    step();
    check_eq("t1_data_addr", bus_if.AddrOut, 32'h0);
    check_eq("t1_data", bus_if.DataOut, 32'h060708AF);
    run_to_done(2, done_at);
    check_eq("t1_done_cycle", 32'(done_at), 32'(DONE_LAT));
    check_eq("t1_error", 32'(Error), 32'h0);
    step();
    check_eq("t1_done_pulse", 32'(Done), 32'h0);
    check_eq("t1_busy_end", 32'(Busy), 32'h0);

    // Stall 2 cycles in ADDR and 1 in DATA
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    check_eq("st_addr0", bus_if.AddrOut, CFG_A);
    bus_if.MasterBusy = 1'b1;
    step();
    check_eq("st_addr1", bus_if.AddrOut, CFG_A);
    step();
    check_eq("st_addr2", bus_if.AddrOut, CFG_A);
    bus_if.MasterBusy = 1'b0;
    step();
    check_eq("st_data0", bus_if.DataOut, 32'h060708AF);
    bus_if.MasterBusy = 1'b1;
    step();
    check_eq("st_data1", bus_if.DataOut, 32'h060708AF);
    check_eq("st_data1_en", 32'(bus_if.EnOut), 32'h1);
    bus_if.MasterBusy = 1'b0;
    run_to_done(5, done_at);
    check_eq("st_done_cycle", 32'(done_at), 32'(DONE_LAT + 3));
    step();

    // Start while busy is ignored
    set_cfg(8'h11, 8'h22, 8'h33, 4'h4, 1'b0, 3'h5);
    rb_from_cfg();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    set_cfg(8'hAA, 8'hBB, 8'hCC, 4'hD, 1'b1, 3'h2);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check_eq("bs_data", bus_if.DataOut, 32'h11223345);
    run_to_done(2, done_at);
    check_eq("bs_done_cycle", 32'(done_at), 32'(DONE_LAT));
    cnt_en = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus_if.EnOut === 1'b1) cnt_en++;
    end
    check_eq("bs_no_second_txn", 32'(cnt_en), 32'h0);

    // Reset during DATA aborts
    rb_from_cfg();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step();
    check_eq("rd_data", bus_if.DataOut, 32'hAABBCCDA);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    check_eq("rd_addr", bus_if.AddrOut, 32'h0);
    check_eq("rd_data0", bus_if.DataOut, 32'h0);
    check_eq("rd_en", 32'(bus_if.EnOut), 32'h0);
    check_eq("rd_busy", 32'(Busy), 32'h0);
    cnt_en = 0; cnt_done = 0; cnt_err = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus_if.EnOut === 1'b1) cnt_en++;
      if (Done === 1'b1) cnt_done++;
      if (Error === 1'b1) cnt_err++;
    end
    check_eq("rd_no_en", 32'(cnt_en), 32'h0);
    check_eq("rd_no_done", 32'(cnt_done), 32'h0);
    check_eq("rd_no_err", 32'(cnt_err), 32'h0);

    set_cfg(8'h01, 8'h02, 8'h03, 4'h4, 1'b0, 3'h1);
    rb_from_cfg();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step();
    check_eq("nw_data", bus_if.DataOut, 32'h01020341);
    run_to_done(2, done_at);
    check_eq("nw_done_cycle", 32'(done_at), 32'(DONE_LAT));
    step();

`ifdef BIU_CFG_VERIFY_EN
    // Persistent tpre mismatch exhausts retries
    set_cfg(8'h06, 8'h07, 8'h08, 4'hA, 1'b1, 3'h7);
    rb_from_cfg();
    rb_tpre = 8'h00;
    run_txn(1'b0, n_addr, done_at, err_at, err0);
    check_eq("rt_txns", 32'(n_addr), 32'd4);
    check_eq("rt_no_done", 32'(done_at), 32'hFFFF_FFFF);
    check_eq("rt_err_cycle", 32'(err_at), 32'd21);
    step(); step(); step();
    check_eq("rt_err_sticky", 32'(Error), 32'h1);
    check_eq("rt_idle", 32'(Busy), 32'h0);

    // prog_mode low on the first check only
    rb_from_cfg();
    rb_prog_mode = 1'b0;
    run_txn(1'b1, n_addr, done_at, err_at, err0);
    check_eq("pm_err_cleared", 32'(err0), 32'h0);
    check_eq("pm_txns", 32'(n_addr), 32'd2);
    check_eq("pm_done_cycle", 32'(done_at), 32'd11);
    check_eq("pm_no_err", 32'(err_at), 32'hFFFF_FFFF);
`else
    // Readback is ignored without verify
    set_cfg(8'h06, 8'h07, 8'h08, 4'hA, 1'b1, 3'h7);
    rb_from_cfg();
    rb_tpre = 8'h00;
    rb_prog_mode = 1'b0;
    run_txn(1'b0, n_addr, done_at, err_at, err0);
    check_eq("nv_txns", 32'(n_addr), 32'd1);
    check_eq("nv_done_cycle", 32'(done_at), 32'd3);
    check_eq("nv_no_err", 32'(err_at), 32'hFFFF_FFFF);
    step(); step();
    check_eq("nv_err_low", 32'(Error), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
